// File: rtl/bp_stream_pump_in.sv
// bp_stream_pump_in
// -----------------
// Receive-side stream pump. Accepts memory messages from the bus as a header
// plus data beats, and presents them to a consuming FSM one beat at a time.
// Each FSM beat carries a per-beat address and a beat index within the block.
// A multi-beat message that carries no payload on the bus is expanded into one
// FSM beat per stream word. The bus-to-FSM path is purely combinational, so
// there is no added latency, no buffering, and backpressure passes straight
// through.
//
// Header layout (LSB first):
//   [3:0]                      msg_type
//   [4 +: paddr_width_p]       addr
//   [4+paddr_width_p +: 3]     size   (message bytes = 1 << size)
//   [7+paddr_width_p +: payload_width_p]  opaque payload, passed through
//
// Ports:
//   clk_i           clock
//   reset_i         asynchronous active-low reset
//   mem_header_i    bus header
//   mem_data_i      bus data beat
//   mem_v_i         bus valid
//   mem_ready_and_o bus ready
//   fsm_header_o    bus header with the addr replaced by the per-beat address
//   fsm_data_o      beat data (passed through from the bus)
//   fsm_v_o         FSM beat valid
//   fsm_yumi_i      FSM consumes the beat (only when fsm_v_o is high)
//   cnt_o           beat index within the block
//   new_o           first beat of a message
//   last_o          final beat of a message
//   done_o          last_o & fsm_yumi_i
//
// Handshakes: the bus side is valid/ready -- a bus beat transfers in a cycle
// where mem_v_i & mem_ready_and_o; the bus keeps header and data stable while
// valid and not accepted. The FSM side is valid/yumi -- fsm_yumi_i may only be
// raised while fsm_v_o is high and means the beat is consumed in that cycle.
//
// Optional build macro: BP_STREAM_PUMP_IN_HEADER_REG_EN
//   When defined, the header of a multi-beat message is captured on the first
//   FSM yumi. The rest of the message is driven from that register, and a
//   no-payload header is released from the bus on the first beat, after which
//   the expanded beats need no bus valid.
//
// State is visible as state_q for checkers.

module bp_stream_pump_in #(
  parameter int          paddr_width_p       = 40,
  parameter int          stream_data_width_p = 64,
  parameter int          block_width_p       = 512,
  parameter int          payload_width_p     = 16,
  parameter logic [15:0] payload_mask_p      = '0,
  localparam int mem_header_width_lp = 4 + paddr_width_p + 3 + payload_width_p
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [mem_header_width_lp-1:0] mem_header_i,
  input  logic [stream_data_width_p-1:0] mem_data_i,
  input  logic                           mem_v_i,
  output logic                           mem_ready_and_o,
  output logic [mem_header_width_lp-1:0] fsm_header_o,
  output logic [stream_data_width_p-1:0] fsm_data_o,
  output logic                           fsm_v_o,
  input  logic                           fsm_yumi_i,
  output logic [((block_width_p/stream_data_width_p) > 1 ? $clog2(block_width_p/stream_data_width_p) : 1)-1:0] cnt_o,
  output logic                           new_o,
  output logic                           last_o,
  output logic                           done_o
);

  localparam int stream_words_lp     = block_width_p / stream_data_width_p;
  localparam int data_len_width_lp   = (stream_words_lp > 1) ? $clog2(stream_words_lp) : 1;
  localparam int stream_bytes_lp     = stream_data_width_p / 8;
  localparam int stream_off_width_lp = (stream_bytes_lp > 1) ? $clog2(stream_bytes_lp) : 1;
  localparam int addr_lsb_lp         = 4;
  localparam int size_lsb_lp         = 4 + paddr_width_p;

`ifdef BP_STREAM_PUMP_IN_HEADER_REG_EN
  localparam bit hdr_reg_en_lp = 1'b1;
`else
  localparam bit hdr_reg_en_lp = 1'b0;
`endif

  typedef enum logic {
    E_READY  = 1'b0,
    E_STREAM = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic [data_len_width_lp-1:0] cnt_q, cnt_d;

  // Header that drives this cycle's beat: the bus, or the captured copy.
  logic [mem_header_width_lp-1:0] src_hdr;

`ifdef BP_STREAM_PUMP_IN_HEADER_REG_EN
  logic [mem_header_width_lp-1:0] hdr_q;
  assign src_hdr = (state_q == E_STREAM) ? hdr_q : mem_header_i;
`else
  assign src_hdr = mem_header_i;
`endif

  logic [3:0]                   src_type;
  logic [paddr_width_p-1:0]     src_addr;
  logic [2:0]                   src_size;
  logic [7:0]                   msg_bytes;
  logic [7:0]                   beats_raw;
  logic                         single_beat;
  logic                         has_data;
  logic [data_len_width_lp-1:0] first_cnt;
  logic [data_len_width_lp-1:0] last_cnt;

  assign src_type  = src_hdr[3:0];
  assign src_addr  = src_hdr[addr_lsb_lp +: paddr_width_p];
  assign src_size  = src_hdr[size_lsb_lp +: 3];
  assign has_data  = payload_mask_p[src_type];
  assign first_cnt = src_addr[stream_off_width_lp +: data_len_width_lp];

  // Messages narrower than one stream word still occupy one beat.
  assign msg_bytes   = 8'd1 << src_size;
  assign beats_raw   = msg_bytes / 8'(stream_bytes_lp);
  assign single_beat = (beats_raw <= 8'd1);
  // Truncation makes last_cnt wrap modulo the block, matching the counter.
  assign last_cnt    = single_beat ? first_cnt
                                   : first_cnt + data_len_width_lp'(beats_raw - 8'd1);

  logic                         fsm_v;
  logic                         mem_rdy;
  logic                         new_b;
  logic                         last_b;
  logic [data_len_width_lp-1:0] cnt_sel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fsm_v   = 1'b0;
    mem_rdy = 1'b0;
    new_b   = 1'b0;
    last_b  = 1'b0;
    cnt_sel = first_cnt;
    case (state_q)
      E_READY: begin
        fsm_v   = mem_v_i;
        new_b   = mem_v_i;
        cnt_sel = first_cnt;
        if (single_beat) begin
          mem_rdy = fsm_yumi_i;
          last_b  = 1'b1;
        end else begin
          // A no-payload header stays on the bus for the whole expansion
          // unless it has been captured locally.
          mem_rdy = (has_data || hdr_reg_en_lp) ? fsm_yumi_i : 1'b0;
          if (fsm_yumi_i) begin
            state_d = E_STREAM;
            cnt_d   = first_cnt + data_len_width_lp'(1);
          end
        end
      end
      E_STREAM: begin
        cnt_sel = cnt_q;
        last_b  = (cnt_q == last_cnt);
        if (has_data) begin
          fsm_v   = mem_v_i;
          mem_rdy = fsm_yumi_i;
        end else if (hdr_reg_en_lp) begin
          fsm_v   = 1'b1;
          mem_rdy = 1'b0;
        end else begin
          fsm_v   = mem_v_i;
          mem_rdy = fsm_yumi_i & last_b;
        end
        if (fsm_yumi_i) begin
          cnt_d = cnt_q + data_len_width_lp'(1);
          if (last_b) begin
            state_d = E_READY;
          end
        end
      end
      default: begin
        state_d = E_READY;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= E_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BP_STREAM_PUMP_IN_HEADER_REG_EN
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      hdr_q <= '0;
    end else if ((state_q == E_READY) && !single_beat && fsm_yumi_i) begin
      hdr_q <= mem_header_i;
    end
  end
`endif

  // Per-beat address: the block-offset field is replaced by the beat index.
  always_comb begin
    fsm_header_o = src_hdr;
    fsm_header_o[addr_lsb_lp + stream_off_width_lp +: data_len_width_lp] = cnt_sel;
  end

  assign fsm_data_o = mem_data_i;
  assign cnt_o      = cnt_sel;

  // Outputs are combinational from the bus, so they are forced low while the
  // asynchronous reset is asserted.
  assign fsm_v_o         = reset_i & fsm_v;
  assign mem_ready_and_o = reset_i & mem_rdy;
  assign new_o           = reset_i & new_b;
  assign last_o          = reset_i & last_b;
  assign done_o          = reset_i & last_b & fsm_yumi_i;

endmodule

// File: doc/bp_stream_pump_in.md
Name: bp_stream_pump_in

Overview:
- Bus-to-FSM stream pump; the receive-side counterpart of the outbound stream pump.
- Accepts BedRock mem messages from the bus as a header plus stream_data_width_p data beats, and presents them to a consuming FSM one beat at a time.
- Each FSM beat carries a per-beat address and a beat counter.
- Multi-beat requests without payload are expanded into per-beat FSM transactions; sits in front of CCE/cache FSMs.

Parameters:
- bp_params_p, e_bp_default_cfg, processor configuration (supplies paddr_width_p, lce_id_width_p, lce_assoc_p, cce_block_width_p, dword_width_p).
- stream_data_width_p, dword_width_p, bits per data beat.
- block_width_p, cce_block_width_p, bits per block; stream_words = block_width_p/stream_data_width_p.
- payload_mask_p, 0, bit per msg_type; 1 = message carries data beats on the bus.
- Derived: data_len_width = SAFE_CLOG2(stream_words); stream_offset_width = SAFE_CLOG2(stream_data_width_p/8).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-low reset.
- mem_header_i  in  xce mem header width  bus header.
- mem_data_i  in  stream_data_width_p  bus data beat.
- mem_v_i  in  1  bus valid.
- mem_ready_and_o  out  1  bus ready; a beat transfers when v & ready.
- fsm_header_o  out  xce mem header width  header with per-beat addr.
- fsm_data_o  out  stream_data_width_p  beat data.
- fsm_v_o  out  1  FSM beat valid.
- fsm_yumi_i  in  1  FSM consumes beat; legal only when fsm_v_o.
- cnt_o  out  data_len_width  beat index within block.
- new_o  out  1  first beat of a message.
- last_o  out  1  final beat of a message.
- done_o  out  1  last_o & fsm_yumi_i.

Behaviour:
- Per-message quantities, taken from the header:
  - num_stream = max((1<<size)/(stream_data_width_p/8), 1).
  - first_cnt = addr[stream_offset_width +: data_len_width].
  - last_cnt = first_cnt + num_stream - 1, truncated to data_len_width; wraps modulo stream_words.
  - has_data = payload_mask_p[msg_type].
- Beat counter:
  - Loaded with first_cnt+1 on the first accepted FSM beat of a multi-beat message.
  - Increments by 1 on each subsequent fsm_yumi_i, wrapping at stream_words.
  - cnt_o = first_cnt in e_ready, counter value in e_stream.
- fsm_header_o:
  - Equals the bus header with addr replaced by {addr[paddr-1:stream_offset_width+data_len_width], cnt_o, addr[stream_offset_width-1:0]}.
  - Size field is unmodified.
- States: e_ready, e_stream.
- e_ready:
  - fsm_v_o = mem_v_i; new_o = mem_v_i.
  - Single beat (num_stream==1): mem_ready_and_o = fsm_yumi_i; last_o = 1; stay in e_ready.
  - Multi-beat, has_data: mem_ready_and_o = fsm_yumi_i; on yumi go to e_stream.
  - Multi-beat, no data: mem_ready_and_o = 0 (header stays on bus); on yumi go to e_stream.
- e_stream:
  - last_o = (cnt_o==last_cnt).
  - has_data: fsm_v_o = mem_v_i; mem_ready_and_o = fsm_yumi_i.
  - No data: fsm_v_o = mem_v_i; mem_ready_and_o = fsm_yumi_i & last_o. The bus header is consumed with the final expanded beat.
  - done_o returns the FSM to e_ready.
- Throughput and latency: 1 beat/cycle; zero latency (combinational bus-to-FSM path). No FSM-side buffering; backpressure propagates directly.
- Boundary conditions:
  - Bus header and data must remain stable while valid and not accepted.
  - Upstream must hold the header stable for all beats of a message.
  - Mismatched num_stream vs. beats supplied is undefined.
  - done_o and new_o can both be high in the same cycle (single-beat message).
- Reset:
  - While reset_i=0: state=e_ready, counter=0, and fsm_v_o, mem_ready_and_o, new_o, last_o, done_o all 0.
  - Asserting reset mid-stream aborts the message immediately; no partial-beat recovery.

Optional Feature:
- Macro: BP_STREAM_PUMP_IN_HEADER_REG_EN.
- Defined:
  - A header register captures mem_header_i on the first FSM yumi of a multi-beat message.
  - In e_stream, fsm_header_o derives from the register and mem_header_i is ignored.
  - No-data expansion sets mem_ready_and_o = fsm_yumi_i in e_ready, consuming the bus header on the first beat. Subsequent expanded beats need no bus valid (fsm_v_o = 1 in e_stream).
  - Register reset value is 0.
- Undefined: no register; behaviour as above.

Test Plan:
- Config: stream_data_width 64, block 512 (8 words).
- uc_rd, size 8B, addr 0x1000, no data -> one FSM beat: addr 0x1000, cnt_o 0, new_o=last_o=1, done_o and mem_ready_and_o high in the yumi cycle.
- wr, size 64B, addr 0x1000, data D0..D7 -> 8 FSM beats: addr 0x1000..0x1038, cnt 0..7, data D0..D7, done_o on the 8th, 8 bus handshakes.
- rd, size 64B, addr 0x1010, no data -> 8 FSM beats: addr 0x1010..0x1038 then 0x1000, 0x1008; cnt 2..7,0,1; mem_ready_and_o high only on the 8th yumi.
- Write stream with fsm_yumi_i low for 3 cycles after beat 3 -> fsm_header_o, fsm_data_o, cnt_o stay at 3; mem_ready_and_o=0; the stream resumes intact.
- reset_i low at beat 4 of a 64B write -> all outputs 0 immediately, cnt 0; after release a new 8B read completes as a single beat.
- With BP_STREAM_PUMP_IN_HEADER_REG_EN defined: 64B rd at 0x1010; bus header consumed on beat 0 and then driven to garbage with mem_v_i=0 -> 8 FSM beats with addrs identical to the no-data rd scenario.
